// File: rtl/config_pkg.sv
// Stand-in for the core configuration package: only the fields the descriptor table reports.
package config_pkg;

   typedef struct packed {
      logic [31:0] XLEN;
      logic        RVA, RVB, RVC, RVD, RVF, RVH, RVS, RVU, RVV;
      logic        RVZCB, RVZCMP, RVZCMT, RVZiCond, RVZicntr, RVZihpm, RVZKN;
      logic        CvxifEn, MmuPresent, DebugEn, PerfCounterEn;
      logic [31:0] IcacheByteSize, IcacheSetAssoc, IcacheLineWidth;
      logic [31:0] DcacheByteSize, DcacheSetAssoc, DcacheLineWidth;
      logic [31:0] DCacheType, WtDcacheWbufDepth, NrLoadBufEntries, MaxOutstandingStores;
      logic [31:0] RASDepth, BTBEntries, BHTEntries, BHTHist;
      logic [31:0] NrPMPEntries, NrScoreboardEntries, NrCommitPorts;
      logic [31:0] InstrTlbEntries, DataTlbEntries;
      logic [63:0] HaltAddress, ExceptionAddress, DmBaseAddress;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cva6_cfg_reporter_pkg.sv
// Descriptor table layout and the word-builder shared by the reporter and its bench.
package cva6_cfg_report_pkg;

   localparam logic [63:0] CfgMagic   = 64'h4356_4136_4346_4731;
   localparam int unsigned NrCfgWords = 12;

   typedef enum logic [3:0] {
      WordMagic, WordMisa, WordZext, WordIcache, WordDcache, WordDcacheCfg,
      WordBpred, WordSizes, WordHalt, WordExc, WordDmBase, WordXor
   } cfg_word_e;

   function automatic logic [63:0] cfg_base_word(config_pkg::cva6_cfg_t cfg, logic [3:0] idx);
      logic [63:0] w;
      w = '0;
      case (cfg_word_e'(idx))
         WordMagic: w = CfgMagic;
         WordMisa: begin
            w[63:62] = (cfg.XLEN == 32'd64) ? 2'd2 : 2'd1;
            w[0]  = cfg.RVA;  w[1]  = cfg.RVB;  w[2]  = cfg.RVC;  w[3] = cfg.RVD;
            w[5]  = cfg.RVF;  w[7]  = cfg.RVH;  w[8]  = 1'b1;     w[12] = 1'b1;
            w[18] = cfg.RVS;  w[20] = cfg.RVU;  w[21] = cfg.RVV;
         end
         WordZext: w[10:0] = {cfg.PerfCounterEn, cfg.DebugEn, cfg.MmuPresent, cfg.CvxifEn,
                              cfg.RVZKN, cfg.RVZihpm, cfg.RVZicntr, cfg.RVZiCond,
                              cfg.RVZCMT, cfg.RVZCMP, cfg.RVZCB};
         WordIcache: w = {cfg.IcacheLineWidth[15:0], cfg.IcacheSetAssoc[15:0], cfg.IcacheByteSize};
         WordDcache: w = {cfg.DcacheLineWidth[15:0], cfg.DcacheSetAssoc[15:0], cfg.DcacheByteSize};
         WordDcacheCfg: begin
            w[3:0]   = cfg.DCacheType[3:0];
            w[15:8]  = cfg.WtDcacheWbufDepth[7:0];
            w[23:16] = cfg.NrLoadBufEntries[7:0];
            w[31:24] = cfg.MaxOutstandingStores[7:0];
         end
         WordBpred: w = {cfg.BHTHist[15:0], cfg.BHTEntries[15:0], cfg.BTBEntries[15:0],
                         cfg.RASDepth[15:0]};
         WordSizes: w[39:0] = {cfg.DataTlbEntries[7:0], cfg.InstrTlbEntries[7:0],
                               cfg.NrCommitPorts[7:0], cfg.NrScoreboardEntries[7:0],
                               cfg.NrPMPEntries[7:0]};
         WordHalt:   w = cfg.HaltAddress;
         WordExc:    w = cfg.ExceptionAddress;
         WordDmBase: w = cfg.DmBaseAddress;
         default:    w = '0;
      endcase
      return w;
   endfunction

   // Word 11 folds words 0..10 so software can sanity-check a full dump.
   function automatic logic [63:0] cfg_word(config_pkg::cva6_cfg_t cfg, logic [3:0] idx);
      logic [63:0] x;
      x = '0;
      if (idx == WordXor) begin
         for (int i = 0; i < NrCfgWords - 1; i++) x ^= cfg_base_word(cfg, 4'(i));
      end else if (idx < 4'(NrCfgWords)) begin
         x = cfg_base_word(cfg, idx);
      end
      return x;
   endfunction

endpackage

// File: rtl/cva6_cfg_reporter_if.sv
// Request/response bundle between a config reader and the descriptor reporter.
interface cva6_cfg_reporter_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [3:0]  req_addr_i;
   logic        dump_i;
   logic        dump_busy_o;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [63:0] rsp_data_o;
   logic        rsp_err_o;
   logic        rsp_last_o;

   modport master (output req_valid_i, req_addr_i, dump_i, rsp_ready_i,
                   input  req_ready_o, dump_busy_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_last_o);
   modport slave  (input  req_valid_i, req_addr_i, dump_i, rsp_ready_i,
                   output req_ready_o, dump_busy_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_last_o);
endinterface

// File: rtl/cva6_cfg_reporter.sv
// Serves the elaborated core configuration as a constant 12-word descriptor table,
// either one word per request or as a streamed dump of all words.
module cva6_cfg_reporter
   import cva6_cfg_report_pkg::*;
#(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
   input  logic               clk_i,
   input  logic               rst_i,
   cva6_cfg_reporter_if.slave bus
);

   localparam int unsigned NrWords = NrCfgWords;
   localparam logic [3:0]  LastIdx = 4'(NrWords - 1);

   typedef enum logic {Idle, Dump} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic        rsp_last_q, rsp_last_d;
   logic [63:0] rsp_data_q, rsp_data_d;
   logic        slot_free, handshake, accept;

   assign slot_free = !rsp_valid_q || bus.rsp_ready_i;
   assign handshake = rsp_valid_q && bus.rsp_ready_i;
   assign accept    = (state_q == Idle) && bus.req_valid_i && slot_free;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_last_d  = rsp_last_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         Idle: begin
            // A request in the same cycle as dump_i wins; the dump pulse is dropped.
            if (accept) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = cfg_word(CVA6Cfg, bus.req_addr_i);
               rsp_err_d   = bus.req_addr_i > LastIdx;
               rsp_last_d  = 1'b0;
            end else if (bus.dump_i && slot_free) begin
               state_d     = Dump;
               cnt_d       = 4'd0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = cfg_word(CVA6Cfg, 4'd0);
               rsp_err_d   = 1'b0;
               rsp_last_d  = 1'b0;
            end else if (handshake) begin
               rsp_valid_d = 1'b0;
            end
         end
         Dump: begin
            if (handshake) begin
               if (cnt_q == LastIdx) begin
                  state_d     = Idle;
                  cnt_d       = 4'd0;
                  rsp_valid_d = 1'b0;
                  rsp_last_d  = 1'b0;
               end else begin
                  cnt_d      = cnt_q + 4'd1;
                  rsp_data_d = cfg_word(CVA6Cfg, cnt_q + 4'd1);
                  rsp_last_d = (cnt_q + 4'd1) == LastIdx;
               end
            end
         end
         default: state_d = Idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= Idle;
         cnt_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_last_q  <= rsp_last_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign bus.req_ready_o = (state_q == Idle) && slot_free;
   assign bus.dump_busy_o = (state_q == Dump);
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_data_o  = rsp_data_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign bus.rsp_last_o  = rsp_last_q;

endmodule

// File: tb/tb_cva6_cfg_reporter.sv
// Scoreboard bench for the configuration descriptor reporter.
module tb_cva6_cfg_reporter;
   import cva6_cfg_report_pkg::*;

   function automatic config_pkg::cva6_cfg_t tb_cfg();
      config_pkg::cva6_cfg_t c;
      c = '0;
      c.XLEN = 32'd64;
      c.RVA = 1'b1; c.RVB = 1'b1; c.RVC = 1'b1; c.RVD = 1'b1; c.RVF = 1'b1;
      c.RVS = 1'b1; c.RVU = 1'b1;
      c.RVZicntr = 1'b1; c.MmuPresent = 1'b1; c.DebugEn = 1'b1;
      c.IcacheByteSize = 32'd16384; c.IcacheSetAssoc = 32'd4; c.IcacheLineWidth = 32'd128;
      c.DcacheByteSize = 32'd32768; c.DcacheSetAssoc = 32'd8; c.DcacheLineWidth = 32'd128;
      c.DCacheType = 32'd2; c.WtDcacheWbufDepth = 32'd8; c.NrLoadBufEntries = 32'd2;
      c.MaxOutstandingStores = 32'd7;
      c.RASDepth = 32'd2; c.BTBEntries = 32'd32; c.BHTEntries = 32'd128; c.BHTHist = 32'd3;
      c.NrPMPEntries = 32'd8; c.NrScoreboardEntries = 32'd8; c.NrCommitPorts = 32'd2;
      c.InstrTlbEntries = 32'd16; c.DataTlbEntries = 32'd16;
      c.HaltAddress = 64'h800; c.ExceptionAddress = 64'h808; c.DmBaseAddress = 64'h0;
      return c;
   endfunction

   localparam config_pkg::cva6_cfg_t TbCfg = tb_cfg();

   typedef struct packed {
      logic [63:0] data;
      logic        err;
      logic        last;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb[$];
   exp_t e;
   int   checks;
   int   errors;

   cva6_cfg_reporter_if bus ();

   cva6_cfg_reporter #(.CVA6Cfg(TbCfg)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid_i = 1'b0; bus.req_addr_i = 4'd0; bus.dump_i = 1'b0; bus.rsp_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_last_o, bus.dump_busy_o} !== 4'b0000 ||
          bus.rsp_data_o !== 64'd0) begin
         errors++;
         $display("FAIL reset_outputs got v%b e%b l%b b%b d%h want all 0", bus.rsp_valid_o,
                  bus.rsp_err_o, bus.rsp_last_o, bus.dump_busy_o, bus.rsp_data_o);
      end
      rst = 1'b0;
      bus.req_valid_i = 1'b1; bus.req_addr_i = 4'd0; bus.rsp_ready_i = 1'b1;
      sb.push_back('{cfg_word(TbCfg, 4'd0), 1'b0, 1'b0});
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      checks++;
      if (bus.rsp_valid_o !== 1'b1) begin
         errors++; $display("FAIL read0_latency got valid %b want 1", bus.rsp_valid_o);
      end
      checks++;
      if (bus.rsp_data_o !== 64'h4356_4136_4346_4731 || bus.rsp_err_o !== 1'b0) begin
         errors++;
         $display("FAIL read0_magic got %h err %b want 4356413643464731 err 0",
                  bus.rsp_data_o, bus.rsp_err_o);
      end
      e = sb.pop_front();
      checks++;
      if ({bus.rsp_data_o, bus.rsp_err_o, bus.rsp_last_o} !== e) begin
         errors++; $display("FAIL read0_sb got %h want %h", bus.rsp_data_o, e.data);
      end
   endtask

   task automatic test_misa();
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_addr_i = 4'd1; bus.rsp_ready_i = 1'b1;
      sb.push_back('{cfg_word(TbCfg, 4'd1), 1'b0, 1'b0});
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 64'h8000_0000_0014_112F) begin
         errors++;
         $display("FAIL misa got v%b %h want v1 800000000014112f", bus.rsp_valid_o, bus.rsp_data_o);
      end
      e = sb.pop_front();
      checks++;
      if ({bus.rsp_data_o, bus.rsp_err_o, bus.rsp_last_o} !== e) begin
         errors++; $display("FAIL misa_sb got %h want %h", bus.rsp_data_o, e.data);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_addr_i = 4'd13; bus.rsp_ready_i = 1'b1;
      sb.push_back('{64'd0, 1'b1, 1'b0});
      @(negedge clk);
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1 || bus.rsp_data_o !== 64'd0) begin
         errors++;
         $display("FAIL err_addr got v%b e%b %h want v1 e1 0", bus.rsp_valid_o, bus.rsp_err_o,
                  bus.rsp_data_o);
      end
      e = sb.pop_front();
      checks++;
      if ({bus.rsp_data_o, bus.rsp_err_o, bus.rsp_last_o} !== e) begin
         errors++; $display("FAIL err_sb got %h/%b want %h/%b", bus.rsp_data_o, bus.rsp_err_o, e.data, e.err);
      end
      checks++;
      if (bus.req_ready_o !== 1'b1) begin
         errors++; $display("FAIL b2b_ready got %b want 1", bus.req_ready_o);
      end
      bus.req_addr_i = 4'd3;
      sb.push_back('{cfg_word(TbCfg, 4'd3), 1'b0, 1'b0});
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0 ||
          bus.rsp_data_o !== {16'd128, 16'd4, 32'd16384}) begin
         errors++;
         $display("FAIL icache got v%b e%b %h want v1 e0 %h", bus.rsp_valid_o, bus.rsp_err_o,
                  bus.rsp_data_o, {16'd128, 16'd4, 32'd16384});
      end
      e = sb.pop_front();
      checks++;
      if ({bus.rsp_data_o, bus.rsp_err_o, bus.rsp_last_o} !== e) begin
         errors++; $display("FAIL icache_sb got %h want %h", bus.rsp_data_o, e.data);
      end
   endtask

   task automatic test_dump_collision();
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_addr_i = 4'd5; bus.dump_i = 1'b1; bus.rsp_ready_i = 1'b1;
      sb.push_back('{cfg_word(TbCfg, 4'd5), 1'b0, 1'b0});
      @(negedge clk);
      bus.req_valid_i = 1'b0; bus.dump_i = 1'b0;
      checks++;
      if (bus.dump_busy_o !== 1'b0) begin
         errors++; $display("FAIL collision_busy got %b want 0", bus.dump_busy_o);
      end
      e = sb.pop_front();
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || {bus.rsp_data_o, bus.rsp_err_o, bus.rsp_last_o} !== e) begin
         errors++; $display("FAIL collision_rsp got v%b %h want v1 %h", bus.rsp_valid_o, bus.rsp_data_o, e.data);
      end
   endtask

   task automatic test_dump();
      int cycles;
      logic [63:0] x;
      logic [63:0] w11;
      x = '0; w11 = '0; cycles = 0;
      @(negedge clk);
      bus.dump_i = 1'b1; bus.rsp_ready_i = 1'b1;
      for (int i = 0; i < 12; i++) sb.push_back('{cfg_word(TbCfg, 4'(i)), 1'b0, i == 11});
      while (sb.size() != 0 && cycles < 40) begin
         @(negedge clk);
         bus.dump_i = 1'b0;
         cycles++;
         if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            e = sb.pop_front();
            checks++;
            if ({bus.rsp_data_o, bus.rsp_err_o, bus.rsp_last_o} !== e) begin
               errors++;
               $display("FAIL dump_word got %h l%b want %h l%b", bus.rsp_data_o, bus.rsp_last_o,
                        e.data, e.last);
            end
            if (sb.size() != 0) x ^= bus.rsp_data_o;
            else w11 = bus.rsp_data_o;
         end
      end
      checks++;
      if (cycles != 12 || sb.size() != 0) begin
         errors++; $display("FAIL dump_cycles got %0d left %0d want 12 left 0", cycles, sb.size());
      end
      checks++;
      if (w11 !== x) begin
         errors++; $display("FAIL dump_xor got %h want %h", w11, x);
      end
      sb.delete();
      @(negedge clk);
      checks++;
      if (bus.dump_busy_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) begin
         errors++; $display("FAIL dump_end got busy %b valid %b want 0 0", bus.dump_busy_o, bus.rsp_valid_o);
      end
   endtask

   task automatic test_dump_stall();
      int cycles;
      logic stall;
      logic [65:0] prev;
      cycles = 0; stall = 1'b0; prev = '0;
      @(negedge clk);
      bus.dump_i = 1'b1; bus.rsp_ready_i = 1'b0;
      for (int i = 0; i < 12; i++) sb.push_back('{cfg_word(TbCfg, 4'(i)), 1'b0, i == 11});
      while (sb.size() != 0 && cycles < 300) begin
         @(negedge clk);
         cycles++;
         // Extra dump pulses while busy must be ignored.
         bus.dump_i = bus.dump_busy_o && ($urandom_range(0, 3) == 0);
         if (stall) begin
            checks++;
            if ({bus.rsp_data_o, bus.rsp_err_o, bus.rsp_last_o} !== prev || bus.rsp_valid_o !== 1'b1) begin
               errors++;
               $display("FAIL stall_stable got v%b %h want v1 %h", bus.rsp_valid_o, bus.rsp_data_o, prev[65:2]);
            end
         end
         checks++;
         if (bus.req_ready_o !== 1'b0) begin
            errors++; $display("FAIL stall_req_ready got %b want 0", bus.req_ready_o);
         end
         bus.rsp_ready_i = ($urandom_range(0, 1) == 1);
         if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            e = sb.pop_front();
            checks++;
            if ({bus.rsp_data_o, bus.rsp_err_o, bus.rsp_last_o} !== e) begin
               errors++;
               $display("FAIL stall_word got %h l%b want %h l%b", bus.rsp_data_o, bus.rsp_last_o,
                        e.data, e.last);
            end
         end
         stall = bus.rsp_valid_o && !bus.rsp_ready_i;
         prev  = {bus.rsp_data_o, bus.rsp_err_o, bus.rsp_last_o};
      end
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL stall_timeout got %0d words left want 0", sb.size());
      end
      sb.delete();
      @(negedge clk);
      bus.dump_i = 1'b0; bus.rsp_ready_i = 1'b1;
      checks++;
      if (bus.dump_busy_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) begin
         errors++; $display("FAIL stall_end got busy %b valid %b want 0 0", bus.dump_busy_o, bus.rsp_valid_o);
      end
   endtask

   task automatic test_reset_mid_dump();
      int cycles;
      int taken;
      cycles = 0; taken = 0;
      @(negedge clk);
      bus.dump_i = 1'b1; bus.rsp_ready_i = 1'b1;
      for (int i = 0; i < 12; i++) sb.push_back('{cfg_word(TbCfg, 4'(i)), 1'b0, i == 11});
      while (taken < 4 && cycles < 40) begin
         @(negedge clk);
         bus.dump_i = 1'b0;
         cycles++;
         if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            e = sb.pop_front();
            taken++;
            checks++;
            if ({bus.rsp_data_o, bus.rsp_err_o, bus.rsp_last_o} !== e) begin
               errors++; $display("FAIL rstdump_word got %h want %h", bus.rsp_data_o, e.data);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== cfg_word(TbCfg, 4'd4)) begin
         errors++; $display("FAIL rstdump_fifth got v%b %h want v1 %h", bus.rsp_valid_o,
                            bus.rsp_data_o, cfg_word(TbCfg, 4'd4));
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid_o !== 1'b0 || bus.dump_busy_o !== 1'b0 || bus.rsp_data_o !== 64'd0) begin
         errors++;
         $display("FAIL rstdump_clear got v%b b%b %h want 0 0 0", bus.rsp_valid_o,
                  bus.dump_busy_o, bus.rsp_data_o);
      end
      sb.delete();
      rst = 1'b0;
      bus.req_valid_i = 1'b1; bus.req_addr_i = 4'd8;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 64'h800 || bus.rsp_err_o !== 1'b0) begin
         errors++; $display("FAIL halt_addr got v%b %h want v1 800", bus.rsp_valid_o, bus.rsp_data_o);
      end
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_misa();
      test_back_to_back();
      test_dump_collision();
      test_dump();
      test_dump_stall();
      test_reset_mid_dump();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
